// File: rtl/ladybird_config.sv
// Shared definitions for the ladybird DMA copy engine: FSM state encoding
// and bus strobe constants.
package ladybird_config;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FIN
   } ladybird_dma_state_t;

   localparam logic [3:0] WSTRB_FULL = 4'hf;
   localparam logic [3:0] WSTRB_NONE = 4'h0;

endpackage

// File: rtl/ladybird_bus.sv
// Ladybird system bus: single shared bidirectional data lane, request/grant
// handshake for commands and a separate grant strobe for returned read data.
interface ladybird_bus;

   logic        req;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   wire  [31:0] data;
   logic        gnt;
   logic        data_gnt;

   modport primary (
      output req,
      output addr,
      output wstrb,
      inout  data,
      input  gnt,
      input  data_gnt
   );

   modport secondary (
      input  req,
      input  addr,
      input  wstrb,
      inout  data,
      output gnt,
      output data_gnt
   );

endinterface

// File: rtl/ladybird_dma.sv
// Word-by-word memory copy engine: read one word, write it back, repeat,
// with a bounded wait for read data.
module ladybird_dma
   import ladybird_config::*;
#(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   ladybird_bus.primary     bus,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   // done is registered one cycle after FIN, so the wait budget from read
   // acceptance to the done pulse comes to TIMEOUT cycles (TIMEOUT >= 3).
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 3);

   ladybird_dma_state_t state_q, state_d;
   logic [31:0]         src_q, src_d;
   logic [31:0]         dst_q, dst_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                err_q, err_d;
   logic                done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      hold_d    = hold_q;
      err_d     = err_q;
      done_d    = (state_q == FIN);
      bus.req   = 1'b0;
      bus.addr  = '0;
      bus.wstrb = WSTRB_NONE;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src;
               dst_d   = dst;
               len_d   = len;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = (len == '0) ? FIN : RD_REQ;
            end
         end
         RD_REQ: begin
            bus.req  = 1'b1;
            bus.addr = src_q;
            if (bus.gnt) begin
               wait_d  = '0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // Arriving data wins over a timeout landing in the same cycle.
            if (bus.data_gnt) begin
               hold_d  = bus.data;
               state_d = WR_REQ;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WR_REQ: begin
            bus.req   = 1'b1;
            bus.addr  = dst_q;
            bus.wstrb = WSTRB_FULL;
            if (bus.gnt) begin
               cnt_d   = cnt_q + LEN_W'(1);
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               state_d = (cnt_d == len_q) ? FIN : RD_REQ;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.data = (state_q == WR_REQ) ? hold_q : 'z;

   assign busy = (state_q != IDLE) || done_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_ladybird_dma.sv
// Directed and randomized copies against a memory model that grants, stalls
// and returns read data; expectations come from the transfer rules.
module tb_ladybird_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, err;

   ladybird_bus bus_if ();

   logic        drv_en  = 1'b0;
   logic [31:0] drv_val = '0;
   assign bus_if.data = drv_en ? drv_val : 'z;

   ladybird_dma #(.DATA_W(32), .LEN_W(16), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus_if),
      .start (start),
      .src   (src),
      .dst   (dst),
      .len   (len),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [logic [29:0]];
   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];
   logic [31:0] exp_q[$];

   int cyc = 0, start_cyc = 0, done_cyc = 0, rd_acc_cyc = 0;
   int done_cnt = 0, req_cycles = 0;
   logic done_err = 1'b0;
   int stall_cfg = 0, stall_left = 0, lat_cfg = 1, rd_left = 0;
   bit req_open = 0, withhold = 0, rd_pend = 0, prev_stall = 0, chk_accept = 0;
   logic [31:0] rd_addr = '0, prev_addr = '0, prev_data = '0, acc_addr = '0;
   logic [3:0]  prev_wstrb = '0, acc_wstrb = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] v);
      mem[a[31:2]] = v;
   endtask

   // One bus cycle: choose gnt, observe the DUT, clock, then apply the
   // memory's reaction (write commit, read data return) for the next cycle.
   task automatic step();
      logic        r;
      logic [31:0] a, d;
      logic [3:0]  w;
      bit          acc;
      if (chk_accept) begin
         check("accepted_once", (bus_if.req && bus_if.addr == acc_addr && bus_if.wstrb == acc_wstrb) ? 32'd1 : 32'd0, 32'd0);
         chk_accept = 0;
      end
      if (bus_if.req && !req_open) begin
         req_open   = 1;
         stall_left = stall_cfg;
      end
      bus_if.gnt = (stall_left == 0);
      r = bus_if.req;
      a = bus_if.addr;
      w = bus_if.wstrb;
      d = bus_if.data;
      if (prev_stall) begin
         check("stall_req", {31'd0, r}, 32'd1);
         check("stall_addr", a, prev_addr);
         check("stall_wstrb", {28'd0, w}, {28'd0, prev_wstrb});
         if (prev_wstrb == 4'hf) check("stall_data", d, prev_data);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = err;
      end
      if (r) req_cycles++;
      acc        = r && bus_if.gnt;
      prev_stall = r && !bus_if.gnt;
      prev_addr  = a;
      prev_wstrb = w;
      prev_data  = d;
      if (prev_stall) stall_left--;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         req_open   = 0;
         chk_accept = 1;
         acc_addr   = a;
         acc_wstrb  = w;
         if (w == 4'h0) begin
            rd_log.push_back(a);
            rd_acc_cyc = cyc - 1;
            rd_pend    = 1;
            rd_left    = lat_cfg;
            rd_addr    = a;
            $display("cycle %0d: READ  addr=%08h", cyc - 1, a);
         end else begin
            check("wr_strb", {28'd0, w}, 32'hf);
            wr_log.push_back(a);
            mem_wr(a, d);
            $display("cycle %0d: WRITE addr=%08h data=%08h", cyc - 1, a, d);
         end
      end
      drv_en          = 1'b0;
      bus_if.data_gnt = 1'b0;
      if (rd_pend && !withhold) begin
         rd_left--;
         if (rd_left == 0) begin
            drv_en          = 1'b1;
            drv_val         = mem_rd(rd_addr);
            bus_if.data_gnt = 1'b1;
            rd_pend         = 0;
         end
      end
   endtask

   task automatic prepare(input logic [31:0] s, input int n);
      rd_log.delete();
      wr_log.delete();
      exp_q.delete();
      done_cnt   = 0;
      req_cycles = 0;
      rd_pend    = 0;
      for (int i = 0; i < n; i++) exp_q.push_back(mem_rd(s + 32'(4 * i)));
   endtask

   // Launch a copy and run until done or budget; optionally re-pulse start
   // with a different command at step restart_at while the copy is running.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input int budget, input int restart_at);
      int k;
      prepare(s, int'(n));
      src = s;
      dst = d;
      len = n;
      start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      k = 1;
      while (done_cnt == 0 && k < budget) begin
         if (k == restart_at) begin
            start = 1'b1;
            src   = 32'h0000_0600;
            len   = 16'd5;
         end
         step();
         start = 1'b0;
         k++;
      end
      check("done_within_budget", done_cnt, 32'd1);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic verify_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                              input int n, input int S, input int L);
      check({tag, "_latency"}, done_cyc - start_cyc, n * (2 * S + L + 2) + 2);
      check({tag, "_err"}, {31'd0, done_err}, 32'd0);
      check({tag, "_nreads"}, rd_log.size(), n);
      check({tag, "_nwrites"}, wr_log.size(), n);
      for (int i = 0; i < n && i < rd_log.size() && i < wr_log.size(); i++) begin
         check({tag, "_rd_addr"}, rd_log[i], s + 32'(4 * i));
         check({tag, "_wr_addr"}, wr_log[i], d + 32'(4 * i));
         check({tag, "_word"}, mem_rd(d + 32'(4 * i)), exp_q[i]);
      end
   endtask

   initial begin
      int k, n, S, L;
      logic [31:0] s, d, w0;
      bus_if.gnt      = 1'b1;
      bus_if.data_gnt = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      check("rst_req", {31'd0, bus_if.req}, 32'd0);
      check("rst_addr", bus_if.addr, 32'd0);
      check("rst_wstrb", {28'd0, bus_if.wstrb}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      // Four-word copy from 0x0 to 0x40, gnt always high, one-cycle read data
      for (int i = 0; i < 4; i++) mem_wr(32'(4 * i), $urandom);
      stall_cfg = 0;
      lat_cfg   = 1;
      run_copy(32'h0, 32'h40, 16'd4, 60, -1);
      verify_copy("copy4", 32'h0, 32'h40, 4, 0, 1);

      // Zero-length copy issues no bus traffic
      run_copy(32'h100, 32'h200, 16'd0, 20, -1);
      check("len0_latency", done_cyc - start_cyc, 32'd2);
      check("len0_req_cycles", req_cycles, 32'd0);
      check("len0_err", {31'd0, done_err}, 32'd0);

      // Five-cycle grant stall on every read and write request
      for (int i = 0; i < 2; i++) mem_wr(32'h100 + 32'(4 * i), $urandom);
      stall_cfg = 5;
      run_copy(32'h100, 32'h200, 16'd2, 100, -1);
      verify_copy("stall5", 32'h100, 32'h200, 2, 5, 1);
      stall_cfg = 0;

      // Read data withheld: timeout, no write, err held afterwards
      mem_wr(32'h380, 32'hDEAD_0380);
      withhold = 1;
      run_copy(32'h300, 32'h380, 16'd3, 60, -1);
      check("tmo_err", {31'd0, done_err}, 32'd1);
      check("tmo_done_after_rd", done_cyc - rd_acc_cyc, 32'd8);
      check("tmo_nreads", rd_log.size(), 32'd1);
      check("tmo_nwrites", wr_log.size(), 32'd0);
      check("tmo_dst_untouched", mem_rd(32'h380), 32'hDEAD_0380);
      repeat (3) step();
      check("tmo_err_held", {31'd0, err}, 32'd1);
      withhold = 0;

      // Reset during the second word's read wait
      for (int i = 0; i < 3; i++) mem_wr(32'h400 + 32'(4 * i), $urandom);
      mem_wr(32'h484, 32'hBEEF_0484);
      lat_cfg = 3;
      prepare(32'h400, 3);
      w0    = mem_rd(32'h400);
      src   = 32'h400;
      dst   = 32'h480;
      len   = 16'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while (rd_log.size() < 2 && k < 40) begin
         step();
         k++;
      end
      check("rstmid_reached_rd2", rd_log.size(), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstmid_req", {31'd0, bus_if.req}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      repeat (12) step();
      check("rstmid_no_done", done_cnt, 32'd0);
      check("rstmid_nwrites", wr_log.size(), 32'd1);
      check("rstmid_word0", mem_rd(32'h480), w0);
      check("rstmid_word1_untouched", mem_rd(32'h484), 32'hBEEF_0484);
      lat_cfg = 1;

      // Source wraps past 0xFFFFFFFC; a second start mid-copy is ignored
      mem_wr(32'hFFFF_FFFC, $urandom);
      run_copy(32'hFFFF_FFFC, 32'h500, 16'd2, 40, 3);
      verify_copy("wrap", 32'hFFFF_FFFC, 32'h500, 2, 0, 1);
      repeat (10) step();
      check("wrap_no_restart", rd_log.size(), 32'd2);

      // Randomized copies: length, read latency and grant stalls vary
      for (int t = 0; t < 6; t++) begin
         n = int'($urandom_range(1, 6));
         L = int'($urandom_range(1, 3));
         S = int'($urandom_range(0, 2));
         s = 32'h1000 + 32'(t * 32'h100);
         d = 32'h8000 + 32'(t * 32'h100);
         for (int i = 0; i < n; i++) mem_wr(s + 32'(4 * i), $urandom);
         lat_cfg   = L;
         stall_cfg = S;
         $display("random copy %0d: len=%0d lat=%0d stall=%0d", t, n, L, S);
         run_copy(s, d, 16'(n), 200, -1);
         verify_copy("rand", s, d, n, S, L);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ladybird_dma.md
LADYBIRD_DMA -- requirements
Module: ladybird_dma

Interface
REQ-001 Parameter DATA_W, default 32: bus data width in bits; only 32 is supported.
REQ-002 Parameter LEN_W, default 16: width of the word-count input and internal counter.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles spent waiting for read data before an error is flagged.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port bus, ladybird_bus.primary: fields req (out), addr (out, 32), wstrb (out, 4), data (inout, 32), gnt (in), data_gnt (in).
REQ-007 Port start, input, 1: one-cycle pulse launching a copy.
REQ-008 Port src, input, 32: word-aligned source byte address, sampled on start.
REQ-009 Port dst, input, 32: word-aligned destination byte address, sampled on start.
REQ-010 Port len, input, LEN_W: number of 32-bit words to copy, sampled on start.
REQ-011 Port busy, output, 1: high from the cycle after an accepted start until the cycle after done.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port err, output, 1: read-timeout error; valid in the done cycle, held until the next start.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, WR_REQ and FIN.
REQ-015 In IDLE, a start SHALL latch src, dst and len, clear err and the word counter, and enter RD_REQ; if len=0 it SHALL enter FIN instead.
REQ-016 A start received outside IDLE SHALL be ignored.
REQ-017 In RD_REQ, the block SHALL drive req=1, addr=current source address, wstrb=0 and data='z.
REQ-018 A request SHALL be accepted in the cycle where req and gnt are both 1; req SHALL stay asserted with stable addr, wstrb and data until accepted.
REQ-019 When a read is accepted, the FSM SHALL enter RD_WAIT with req=0; at most one read SHALL be outstanding.
REQ-020 In RD_WAIT, bus.data SHALL be captured into the holding register in the cycle data_gnt=1, and the FSM SHALL enter WR_REQ; data_gnt in any other state SHALL be ignored.
REQ-021 In WR_REQ, the block SHALL drive req=1, addr=current destination address, wstrb=4'hf and data=holding register.
REQ-022 When a write is accepted, the counter SHALL increment and the source and destination addresses SHALL each advance by 4, wrapping modulo 2^32; if the new count equals len the FSM SHALL enter FIN, otherwise RD_REQ.
REQ-023 A RD_WAIT cycle counter SHALL reset on entry to RD_WAIT; if TIMEOUT cycles pass without data_gnt, the block SHALL set err=1 and enter FIN, and no write SHALL be issued.
REQ-024 In FIN, the block SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-025 With gnt tied to 1 and read data arriving one cycle after acceptance, each word SHALL take 3 cycles; a copy of N words SHALL raise done 3N+2 cycles after the start cycle.
REQ-026 Outside RD_REQ and WR_REQ, the block SHALL drive req=0 and wstrb=0, and SHALL drive data 'z whenever it is not in WR_REQ.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be IDLE, with req=0, addr=0, wstrb=0, data='z, busy=0, done=0, err=0, counters=0 and holding register=0.
REQ-028 Reset asserted mid-copy SHALL abandon the transfer immediately without a done pulse; a late data_gnt after reset SHALL be ignored.

Structure
REQ-029 The state enum ladybird_dma_state_t and the constant for the full write strobe SHALL be placed in package ladybird_config.
REQ-030 The block SHALL be a single module with no sub-modules; the FSM, counters and holding register SHALL be local.

Verification
REQ-031 With ladybird_ram attached, ram[0..3]=A,B,C,D, src=0x0, dst=0x40 and len=4 -> ram[16..19]=A,B,C,D, done in cycle 14 after start, and err=0.
REQ-032 len=0 -> no bus request is issued and done pulses 2 cycles after start.
REQ-033 gnt held low for 5 cycles in both RD_REQ and WR_REQ -> req, addr, wstrb and data stay stable, and each is accepted in the first gnt=1 cycle.
REQ-034 data_gnt withheld with TIMEOUT=8 -> err=1 with done 8 cycles after read acceptance, and no write is observed.
REQ-035 rst pulsed during the second word's RD_WAIT -> req=0 and busy=0 on the next cycle, no done pulse, and the destination holds only the first word.
REQ-036 start pulsed again while busy, and src=0xFFFFFFFC with len=2 -> the second start is ignored, and the source address wraps to 0x00000000.
